// File: rtl/conf_frame_ctrl_pkg.sv
// Shared types and constants for the framed configuration controller.
// Included by the interface, the frame timer and the top level.
package conf_frame_ctrl_pkg;

    localparam int unsigned CONF_PAR_NUM = 5;
    localparam int unsigned IDX_W        = $clog2(CONF_PAR_NUM);
    localparam int unsigned TIMEOUT_MAX  = 2047;
    localparam int unsigned TMR_W        = $clog2(TIMEOUT_MAX + 1);
    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

    typedef enum logic [IDX_W-1:0] {
        CP_PERIOD,
        CP_ON_TIME,
        CP_DEAD_TIME,
        CP_PHASE_LEAD,
        CP_OCD_LIMIT
    } Conf_par;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        PEND
    } Frame_state;

    typedef logic [7:0] conf_arr_t [CONF_PAR_NUM];

endpackage

// File: rtl/conf_frame_ctrl_if.sv
// Byte-receiver / timing-core side signals of the configuration controller.
interface conf_frame_ctrl_if;
    import conf_frame_ctrl_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       safe;
    conf_arr_t  conf_par;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx_data, rx_valid, safe,
        input  conf_par, frame_ok, frame_err, busy
    );

    modport slave (
        input  rx_data, rx_valid, safe,
        output conf_par, frame_ok, frame_err, busy
    );

endinterface

// File: rtl/conf_frame_ctrl_frame_timer.sv
// Inter-byte watchdog: loadable down-counter that saturates at zero.
module frame_timer
    import conf_frame_ctrl_pkg::*;
#(
    parameter int unsigned LOAD = TIMEOUT_MAX
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = $clog2(LOAD + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= W'(LOAD);
        end else if (reload) begin
            r_count <= W'(LOAD);
        end else if (run && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/conf_frame_ctrl.sv
// Collects sync + payload + checksum into a shadow store and commits it to the
// active parameters atomically, only at a safe point signalled by the core.
module conf_frame_ctrl
    import conf_frame_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    conf_frame_ctrl_if.slave bus
);

    Frame_state       r_state;
    Frame_state       w_next;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_sum;
    conf_arr_t        r_shadow;
    conf_arr_t        r_conf_par;
    logic             r_ok;
    logic             r_err;
    logic             r_busy;

    logic w_sync;
    logic w_last;
    logic w_reload;
    logic w_run;
    logic w_expired;
    logic w_err;
    logic w_commit;

    assign w_sync = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    assign w_last = (r_idx == IDX_W'(CONF_PAR_NUM - 1));

    frame_timer #(.LOAD(TIMEOUT_MAX)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .reload  (w_reload),
        .run     (w_run),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    always_comb begin
        w_next   = r_state;
        w_reload = 1'b0;
        w_run    = 1'b0;
        w_err    = 1'b0;
        w_commit = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_sync) begin
                    w_next   = PAYLOAD;
                    w_reload = 1'b1;
                end
            end
            PAYLOAD: begin
                if (bus.rx_valid) begin
                    w_reload = 1'b1;
                    if (w_last) w_next = CHECK;
                end else if (w_expired) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end else begin
                    w_run = 1'b1;
                end
            end
            CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == r_sum) begin
                        w_next = PEND;
                    end else begin
                        w_next = IDLE;
                        w_err  = 1'b1;
                    end
                end else if (w_expired) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end else begin
                    w_run = 1'b1;
                end
            end
            PEND: begin
                if (bus.safe) begin
                    w_next   = IDLE;
                    w_commit = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_sum  <= '0;
            r_ok   <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
            for (int unsigned i = 0; i < CONF_PAR_NUM; i++) begin
                r_shadow[i]   <= '0;
                r_conf_par[i] <= '0;
            end
        end else begin
            r_ok   <= w_commit;
            r_err  <= w_err;
            r_busy <= (w_next != IDLE);
            if ((r_state == IDLE) && w_sync) begin
                r_idx <= '0;
                r_sum <= '0;
            end
            if ((r_state == PAYLOAD) && bus.rx_valid) begin
                for (int unsigned i = 0; i < CONF_PAR_NUM; i++) begin
                    if (r_idx == IDX_W'(i)) r_shadow[i] <= bus.rx_data;
                end
                r_sum <= r_sum + bus.rx_data;
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_commit) begin
                for (int unsigned i = 0; i < CONF_PAR_NUM; i++) begin
                    r_conf_par[i] <= r_shadow[i];
                end
            end
        end
    end

    assign bus.conf_par  = r_conf_par;
    assign bus.frame_ok  = r_ok;
    assign bus.frame_err = r_err;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_conf_frame_ctrl.sv
// Self-checking bench for conf_frame_ctrl: directed scenarios plus random frames
// checked against a frame-level model (sum mod 256, commit only on safe).
module tb_conf_frame_ctrl;
    import conf_frame_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    conf_frame_ctrl_if bus();

    conf_frame_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    conf_arr_t   exp_conf;

    function automatic logic [8*CONF_PAR_NUM-1:0] act_packed();
        logic [8*CONF_PAR_NUM-1:0] p = '0;
        for (int unsigned i = 0; i < CONF_PAR_NUM; i++) p = {p[8*CONF_PAR_NUM-9:0], bus.conf_par[i]};
        return p;
    endfunction

    function automatic logic [8*CONF_PAR_NUM-1:0] exp_packed();
        logic [8*CONF_PAR_NUM-1:0] p = '0;
        for (int unsigned i = 0; i < CONF_PAR_NUM; i++) p = {p[8*CONF_PAR_NUM-9:0], exp_conf[i]};
        return p;
    endfunction

    function automatic logic [7:0] model_sum(input conf_arr_t pl);
        int unsigned s = 0;
        for (int unsigned i = 0; i < CONF_PAR_NUM; i++) s += pl[i];
        return 8'(s % 256);
    endfunction

    // All drive helpers assume they are entered right at a falling edge.
    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input conf_arr_t pl, input logic [7:0] cks, input int unsigned max_gap);
        send_byte(SYNC_BYTE);
        for (int unsigned i = 0; i < CONF_PAR_NUM; i++) begin
            idle($urandom_range(0, max_gap));
            send_byte(pl[i]);
        end
        idle($urandom_range(0, max_gap));
        send_byte(cks);
    endtask

    task automatic test_reset();
        for (int unsigned i = 0; i < CONF_PAR_NUM; i++) exp_conf[i] = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: busy/ok/err=%b%b%b required 000", bus.busy, bus.frame_ok, bus.frame_err);
        end
        n_checks++;
        if (act_packed() !== exp_packed()) begin
            n_errors++;
            $display("FAIL reset_conf: got %h required %h", act_packed(), exp_packed());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        n_checks++;
        if (bus.busy !== 1'b0 || act_packed() !== exp_packed()) begin
            n_errors++;
            $display("FAIL reset_release: busy=%b conf=%h required 0 %h", bus.busy, act_packed(), exp_packed());
        end
    endtask

    task automatic test_valid_frame();
        conf_arr_t pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        bus.safe = 1'b1;
        send_frame(pl, 8'hF0, 0);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.frame_ok !== 1'b0 || act_packed() !== exp_packed()) begin
            n_errors++;
            $display("FAIL valid_pend: busy=%b ok=%b conf=%h required 1 0 %h", bus.busy, bus.frame_ok, act_packed(), exp_packed());
        end
        idle(1);
        exp_conf = pl;
        n_checks++;
        if (act_packed() !== exp_packed()) begin
            n_errors++;
            $display("FAIL valid_commit: got %h required %h", act_packed(), exp_packed());
        end
        n_checks++;
        if (bus.frame_ok !== 1'b1 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL valid_ok: ok=%b busy=%b required 1 0", bus.frame_ok, bus.busy);
        end
        idle(1);
        n_checks++;
        if (bus.frame_ok !== 1'b0) begin
            n_errors++;
            $display("FAIL valid_ok_width: ok=%b required 0", bus.frame_ok);
        end
    endtask

    task automatic test_bad_checksum();
        conf_arr_t pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        pl[0] = 8'h11;  // differs from the committed set so a wrong commit is visible
        bus.safe = 1'b1;
        send_frame(pl, model_sum(pl) ^ 8'h01, 2);
        n_checks++;
        if (bus.frame_err !== 1'b1 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL badcks_err: err=%b busy=%b required 1 0", bus.frame_err, bus.busy);
        end
        idle(1);
        n_checks++;
        if (bus.frame_err !== 1'b0 || bus.frame_ok !== 1'b0 || act_packed() !== exp_packed()) begin
            n_errors++;
            $display("FAIL badcks_after: err=%b ok=%b conf=%h required 0 0 %h", bus.frame_err, bus.frame_ok, act_packed(), exp_packed());
        end
    endtask

    task automatic test_timeout();
        int unsigned first = 0;
        conf_arr_t pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        conf_arr_t pr;
        bus.safe = 1'b1;
        send_byte(SYNC_BYTE);
        send_byte(8'h01);
        send_byte(8'h02);
        for (int unsigned n = 1; n <= TIMEOUT_MAX + 3; n++) begin
            idle(1);
            if (bus.frame_err === 1'b1 && first == 0) first = n;
        end
        n_checks++;
        if (first != TIMEOUT_MAX + 1) begin
            n_errors++;
            $display("FAIL timeout_edge: err after %0d silent clocks required %0d", first, TIMEOUT_MAX + 1);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || act_packed() !== exp_packed()) begin
            n_errors++;
            $display("FAIL timeout_state: busy=%b conf=%h required 0 %h", bus.busy, act_packed(), exp_packed());
        end
        send_frame(pl, 8'h0F, 0);
        idle(1);
        exp_conf = pl;
        n_checks++;
        if (act_packed() !== exp_packed() || bus.frame_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_recover: conf=%h ok=%b required %h 1", act_packed(), bus.frame_ok, exp_packed());
        end
        // Byte lands on the very edge where the timer has run out.
        for (int unsigned i = 0; i < CONF_PAR_NUM; i++) pr[i] = 8'($urandom);
        idle(1);
        send_byte(SYNC_BYTE);
        idle(TIMEOUT_MAX);
        send_byte(pr[0]);
        n_checks++;
        if (bus.frame_err !== 1'b0 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL byte_wins: err=%b busy=%b required 0 1", bus.frame_err, bus.busy);
        end
        for (int unsigned i = 1; i < CONF_PAR_NUM; i++) send_byte(pr[i]);
        send_byte(model_sum(pr));
        idle(1);
        exp_conf = pr;
        n_checks++;
        if (act_packed() !== exp_packed()) begin
            n_errors++;
            $display("FAIL byte_wins_commit: got %h required %h", act_packed(), exp_packed());
        end
        idle(1);
    endtask

    task automatic test_safe_gating();
        conf_arr_t pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic seen_err = 1'b0;
        bus.safe = 1'b0;
        send_frame(pl, model_sum(pl), 1);
        idle(100);
        n_checks++;
        if (act_packed() !== exp_packed() || bus.busy !== 1'b1 || bus.frame_ok !== 1'b0) begin
            n_errors++;
            $display("FAIL gate_hold: conf=%h busy=%b ok=%b required %h 1 0", act_packed(), bus.busy, bus.frame_ok, exp_packed());
        end
        send_byte(SYNC_BYTE);
        if (bus.frame_err === 1'b1) seen_err = 1'b1;
        send_byte(8'hFF);
        if (bus.frame_err === 1'b1) seen_err = 1'b1;
        n_checks++;
        if (seen_err !== 1'b0 || bus.busy !== 1'b1 || act_packed() !== exp_packed()) begin
            n_errors++;
            $display("FAIL gate_ignore: err_seen=%b busy=%b conf=%h required 0 1 %h", seen_err, bus.busy, act_packed(), exp_packed());
        end
        bus.safe = 1'b1;
        idle(1);
        exp_conf = pl;
        n_checks++;
        if (act_packed() !== exp_packed() || bus.frame_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL gate_commit: conf=%h ok=%b required %h 1", act_packed(), bus.frame_ok, exp_packed());
        end
        idle(1);
    endtask

    task automatic test_reset_mid_frame();
        conf_arr_t pl = '{8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
        logic seen = 1'b0;
        bus.safe = 1'b1;
        send_byte(SYNC_BYTE);
        send_byte(8'h10);
        send_byte(8'h20);
        #2 rst_n = 1'b0;
        #1;
        for (int unsigned i = 0; i < CONF_PAR_NUM; i++) exp_conf[i] = '0;
        n_checks++;
        if (act_packed() !== exp_packed() || bus.busy !== 1'b0 || bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_outputs: conf=%h busy/ok/err=%b%b%b required %h 000", act_packed(), bus.busy, bus.frame_ok, bus.frame_err, exp_packed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            send_byte(pl[i]);
            if (bus.busy !== 1'b0 || bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_discard: activity=%b required 0", seen);
        end
        send_frame(pl, model_sum(pl), 0);
        idle(1);
        exp_conf = pl;
        n_checks++;
        if (act_packed() !== exp_packed()) begin
            n_errors++;
            $display("FAIL midreset_next: got %h required %h", act_packed(), exp_packed());
        end
        idle(1);
    endtask

    task automatic test_wrap();
        conf_arr_t pf = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        conf_arr_t pa = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h01};
        bus.safe = 1'b1;
        send_frame(pf, 8'hFB, 0);
        idle(1);
        exp_conf = pf;
        n_checks++;
        if (act_packed() !== exp_packed() || bus.frame_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_ff: conf=%h ok=%b required %h 1", act_packed(), bus.frame_ok, exp_packed());
        end
        idle(1);
        send_frame(pa, 8'hF0, 0);
        idle(1);
        exp_conf = pa;
        n_checks++;
        if (act_packed() !== exp_packed() || bus.frame_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL sync_as_data: conf=%h ok=%b required %h 1", act_packed(), bus.frame_ok, exp_packed());
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        conf_arr_t p1;
        conf_arr_t p2;
        for (int unsigned i = 0; i < CONF_PAR_NUM; i++) begin
            p1[i] = 8'($urandom);
            p2[i] = 8'($urandom);
        end
        bus.safe = 1'b1;
        send_frame(p1, model_sum(p1), 0);
        idle(1);
        exp_conf = p1;
        n_checks++;
        if (act_packed() !== exp_packed() || bus.frame_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_first: conf=%h ok=%b required %h 1", act_packed(), bus.frame_ok, exp_packed());
        end
        send_frame(p2, model_sum(p2), 0);
        idle(1);
        exp_conf = p2;
        n_checks++;
        if (act_packed() !== exp_packed() || bus.frame_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_second: conf=%h ok=%b required %h 1", act_packed(), bus.frame_ok, exp_packed());
        end
        idle(1);
    endtask

    task automatic test_random_frames();
        conf_arr_t   pl;
        logic [7:0]  cks;
        logic [7:0]  junk;
        logic        good;
        int unsigned dly;
        for (int unsigned t = 0; t < 25; t++) begin
            bus.safe = 1'b0;
            for (int unsigned i = 0; i < CONF_PAR_NUM; i++) pl[i] = 8'($urandom);
            good = 1'($urandom_range(0, 1));
            cks  = good ? model_sum(pl) : model_sum(pl) ^ 8'($urandom_range(1, 255));
            dly  = $urandom_range(0, 4);
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == SYNC_BYTE) junk = 8'h5A;
                send_byte(junk);
            end
            send_frame(pl, cks, 3);
            if (cks == model_sum(pl)) begin
                idle(dly);
                n_checks++;
                if (bus.busy !== 1'b1 || act_packed() !== exp_packed()) begin
                    n_errors++;
                    $display("FAIL rand_pend[%0d]: busy=%b conf=%h required 1 %h", t, bus.busy, act_packed(), exp_packed());
                end
                bus.safe = 1'b1;
                idle(1);
                exp_conf = pl;
                n_checks++;
                if (act_packed() !== exp_packed() || bus.frame_ok !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rand_commit[%0d]: conf=%h ok=%b required %h 1", t, act_packed(), bus.frame_ok, exp_packed());
                end
            end else begin
                n_checks++;
                if (bus.frame_err !== 1'b1 || act_packed() !== exp_packed()) begin
                    n_errors++;
                    $display("FAIL rand_reject[%0d]: err=%b conf=%h required 1 %h", t, bus.frame_err, act_packed(), exp_packed());
                end
            end
            idle(1);
        end
    endtask

    initial begin
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.safe     = 1'b0;
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_timeout();
        test_safe_gating();
        test_reset_mid_frame();
        test_wrap();
        test_back_to_back();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
